// File: rtl/det_pkg.sv
// Shared definitions for the 101-detect window counter: FSM encoding and default widths.
package det_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;
endpackage

// File: rtl/det_win_timer.sv
// Window timer: loads the window length (0 means 1), counts down, flags the last window cycle.
module det_win_timer #(
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIN_W-1:0] len,
    input  logic             dec,
    output logic             last
);
    logic [WIN_W-1:0] rem;

    // rem holds the window cycles still to run, including the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem <= '0;
        else if (load)
            rem <= (len == '0) ? WIN_W'(1) : len;
        else if (dec && rem != '0)
            rem <= rem - 1'b1;
    end

    assign last = (rem == WIN_W'(1));
endmodule

// File: rtl/det_window_counter.sv
// Counts detect pulses over fixed-length windows and hands each window's count to a
// single-entry valid/ready output register, dropping results the consumer cannot take.
module det_window_counter
    import det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_ovf,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             win_last;
    logic             tmr_load;
    logic             tmr_dec;
    logic             at_max;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             offer;

    // Reload both on window start from IDLE and on a seamless back-to-back window.
    assign tmr_load = en && ((state == IDLE) || win_last);
    assign tmr_dec  = (state == COUNT) && en;

    det_win_timer #(.WIN_W(WIN_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .len  (win_len),
        .dec  (tmr_dec),
        .last (win_last)
    );

    assign at_max  = (cnt == {CNT_W{1'b1}});
    assign cnt_nxt = (det_in && !at_max) ? cnt + 1'b1 : cnt;
    assign ovf_nxt = ovf | (det_in & at_max);
    assign offer   = (state == COUNT) && win_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (en)  state <= COUNT;
                COUNT:   if (!en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == IDLE || win_last || !en) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    // The count offered includes the last window cycle's pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_out   <= '0;
            cnt_ovf   <= 1'b0;
            cnt_valid <= 1'b0;
            drop      <= 1'b0;
        end else if (offer) begin
            if (!cnt_valid || cnt_ready) begin
                cnt_out   <= cnt_nxt;
                cnt_ovf   <= ovf_nxt;
                cnt_valid <= 1'b1;
                drop      <= 1'b0;
            end else begin
                drop <= 1'b1;
            end
        end else begin
            drop <= 1'b0;
            if (cnt_valid && cnt_ready)
                cnt_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_det_window_counter.sv
// Bench for det_window_counter: directed scenarios plus random traffic against a window-level model,
// run on a default-width instance and a 2-bit-count instance sharing the same inputs.
module tb_det_window_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       det_in = 1'b0;
    logic [7:0] win_len = 8'd0;
    logic       cnt_ready = 1'b0;

    logic [7:0] out0;
    logic       ovf0, vld0, drop0;
    logic [1:0] out1;
    logic       ovf1, vld1, drop1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    det_window_counter #(.CNT_W(8), .WIN_W(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .det_in(det_in), .win_len(win_len),
        .cnt_out(out0), .cnt_ovf(ovf0), .cnt_valid(vld0), .cnt_ready(cnt_ready), .drop(drop0)
    );

    det_window_counter #(.CNT_W(2), .WIN_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .det_in(det_in), .win_len(win_len),
        .cnt_out(out1), .cnt_ovf(ovf1), .cnt_valid(vld1), .cnt_ready(cnt_ready), .drop(drop1)
    );

    // Window-level model: position counts up from 1, events accumulate unbounded,
    // saturation is applied only when the window result is produced.
    int  maxv [2] = '{255, 3};
    bit  m_act;
    int  m_pos, m_len, m_ev;
    bit  m_vld [2];
    int  m_out [2];
    bit  m_ovf [2];
    bit  m_drop[2];

    task automatic model_reset();
        m_act = 0; m_pos = 0; m_len = 0; m_ev = 0;
        for (int k = 0; k < 2; k++) begin
            m_vld[k] = 0; m_out[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit offer = 0;
        int res = 0;
        int wl = (win_len == 0) ? 1 : int'(win_len);
        if (!m_act) begin
            if (en) begin
                m_act = 1; m_len = wl; m_pos = 1; m_ev = 0;
            end
        end else begin
            int ev_now = m_ev + int'(det_in);
            if (m_pos == m_len) begin
                offer = 1; res = ev_now;
                if (en) begin
                    m_len = wl; m_pos = 1; m_ev = 0;
                end else begin
                    m_act = 0;
                end
            end else if (!en) begin
                m_act = 0;
            end else begin
                m_pos++; m_ev = ev_now;
            end
        end
        for (int k = 0; k < 2; k++) begin
            m_drop[k] = 0;
            if (offer) begin
                if (!m_vld[k] || cnt_ready) begin
                    m_vld[k] = 1;
                    m_out[k] = (res > maxv[k]) ? maxv[k] : res;
                    m_ovf[k] = (res > maxv[k]);
                end else begin
                    m_drop[k] = 1;
                end
            end else if (m_vld[k] && cnt_ready) begin
                m_vld[k] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_out0"}, int'(out0), m_out[0]);
        chk({tag, "_ovf0"}, int'(ovf0), int'(m_ovf[0]));
        chk({tag, "_vld0"}, int'(vld0), int'(m_vld[0]));
        chk({tag, "_drop0"}, int'(drop0), int'(m_drop[0]));
        chk({tag, "_out1"}, int'(out1), m_out[1]);
        chk({tag, "_ovf1"}, int'(ovf1), int'(m_ovf[1]));
        chk({tag, "_vld1"}, int'(vld1), int'(m_vld[1]));
        chk({tag, "_drop1"}, int'(drop1), int'(m_drop[1]));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    // Called at posedge+1: asserts reset between edges so the clear must be asynchronous.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk_model(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        chk_model("reset_state");
        @(posedge clk); #1;
        chk_model("reset_hold");
        rst = 1'b0;
        step("idle_no_en");

        // Basic window: length 5, pulses in window cycles 1 and 4.
        en = 1; win_len = 8'd5; cnt_ready = 1;
        step("basic_start");
        det_in = 1; step("basic_c1");
        det_in = 0; step("basic_c2");
        step("basic_c3");
        det_in = 1; step("basic_c4");
        det_in = 0;
        chk("basic_vld_early", int'(vld0), 0);
        step("basic_c5");
        chk("basic_out", int'(out0), 2);
        chk("basic_vld", int'(vld0), 1);
        chk("basic_ovf", int'(ovf0), 0);

        // Back-to-back windows of 3 with a pulse every cycle.
        async_reset("rst_b2b");
        en = 1; win_len = 8'd3; det_in = 1; cnt_ready = 1;
        step("b2b_start");
        for (int i = 0; i < 9; i++) step("b2b");
        chk("b2b_out", int'(out0), 3);

        // Saturation on the 2-bit instance, then zero-length windows.
        async_reset("rst_sat");
        en = 1; win_len = 8'd6; det_in = 0; cnt_ready = 1;
        step("sat_start");
        det_in = 1; win_len = 8'd1;
        for (int i = 0; i < 6; i++) step("sat");
        chk("sat_out1", int'(out1), 3);
        chk("sat_ovf1", int'(ovf1), 1);
        chk("sat_out0", int'(out0), 6);
        win_len = 8'd0;
        step("zero_tail");
        for (int i = 0; i < 4; i++) begin
            det_in = i[0];
            step("zero_len");
            chk("zero_len_vld", int'(vld0), 1);
            chk("zero_len_out", int'(out0), i & 1);
        end

        // Backpressure with 2-cycle windows.
        async_reset("rst_bp");
        en = 1; win_len = 8'd2; det_in = 1; cnt_ready = 0;
        step("bp_start");
        step("bp_w1c1");
        step("bp_w1c2");
        chk("bp_first_out", int'(out0), 2);
        det_in = 0;
        step("bp_w2c1");
        step("bp_w2c2");
        chk("bp_drop", int'(drop0), 1);
        chk("bp_hold", int'(out0), 2);
        step("bp_w3c1");
        chk("bp_drop_once", int'(drop0), 0);
        cnt_ready = 1;
        step("bp_w3c2");
        chk("bp_reload_out", int'(out0), 0);
        chk("bp_reload_vld", int'(vld0), 1);
        chk("bp_reload_nodrop", int'(drop0), 0);

        // Abort in window cycle 4, then a fresh full window.
        async_reset("rst_abort");
        en = 1; win_len = 8'd10; det_in = 1; cnt_ready = 0;
        step("ab_start");
        for (int i = 0; i < 3; i++) step("ab_pre");
        en = 0;
        step("ab_c4");
        step("ab_idle");
        chk("ab_novld", int'(vld0), 0);
        chk("ab_nodrop", int'(drop0), 0);
        en = 1;
        step("ab_restart");
        for (int i = 0; i < 9; i++) step("ab_full");
        chk("ab_full_novld", int'(vld0), 0);
        step("ab_full_end");
        chk("ab_full_out", int'(out0), 10);
        chk("ab_full_vld", int'(vld0), 1);
        step("ab_mid");
        step("ab_mid2");
        async_reset("async_mid");
        chk("async_vld", int'(vld0), 0);
        step("post_rst_idle");

        // Random traffic with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            det_in    = $urandom_range(0, 1);
            win_len   = 8'($urandom_range(0, 6));
            cnt_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/det_window_counter.md
DET_WINDOW_COUNTER -- requirements
Module: det_window_counter

Interface
REQ-001 Parameter CNT_W, default 8: width of the event count and of cnt_out.
REQ-002 Parameter WIN_W, default 8: width of win_len.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous and active-high.
REQ-005 Port en, input, 1: enables counting windows.
REQ-006 Port det_in, input, 1: one-cycle detect pulse from the upstream 101 sequence detector (its d_out); each high cycle is one event.
REQ-007 Port win_len, input, WIN_W: window length in cycles.
REQ-008 Port cnt_out, output, CNT_W: event count of the last completed window.
REQ-009 Port cnt_ovf, output, 1: the count in cnt_out saturated.
REQ-010 Port cnt_valid, output, 1: cnt_out/cnt_ovf hold an unconsumed result.
REQ-011 Port cnt_ready, input, 1: the consumer accepts the result.
REQ-012 Port drop, output, 1: one-cycle pulse when a completed window result is discarded.

Function
REQ-013 The FSM SHALL have two states: IDLE and COUNT.
- IDLE -> COUNT: en=1 sampled at a rising edge.
- COUNT -> IDLE: en=0 sampled at a rising edge.
- All other cases: stay in the current state.
REQ-014 The first window cycle SHALL be the cycle after the IDLE->COUNT edge; det_in SHALL be ignored in IDLE.
REQ-015 win_len SHALL be sampled at each window start; changes mid-window SHALL have no effect; win_len=0 SHALL be treated as 1.
REQ-016 A window SHALL span exactly L cycles (L = sampled length), and det_in SHALL be counted in every one of them, including the last.
REQ-017 The event count SHALL saturate at 2^CNT_W-1, with an internal ovf flag set on any attempted increment past saturation.
REQ-018 At the edge ending the last window cycle, the count/ovf SHALL be offered to the output register; if en=1 the next window SHALL start immediately (no gap) with count 0, ovf 0, and win_len resampled.
REQ-019 If en=0 at the edge ending a window, the completed result SHALL still be offered to the output register and the FSM SHALL go to IDLE.
REQ-020 If en=0 is sampled before the last window cycle, the partial count SHALL be discarded, no result SHALL be offered, and drop SHALL NOT pulse.
REQ-021 The output register SHALL load an offered result when cnt_valid=0, or when cnt_valid=1 and cnt_ready=1 at the same edge; cnt_valid SHALL then be 1.
REQ-022 If cnt_valid=1 and cnt_ready=0 when a result is offered, cnt_out/cnt_ovf SHALL hold, the new result SHALL be discarded, and drop SHALL be high for exactly the next cycle.
REQ-023 cnt_valid SHALL fall after a handshake edge (cnt_valid=1, cnt_ready=1) when no result is offered at that edge.
REQ-024 cnt_out/cnt_ovf SHALL remain stable while cnt_valid=1 and no handshake has occurred.
REQ-025 Latency SHALL be one cycle: cnt_valid rises in the cycle after the last window cycle.

Reset
REQ-026 While rst=1, the block SHALL immediately force: state IDLE, window timer 0, count 0, ovf 0, cnt_out 0, cnt_ovf 0, cnt_valid 0, drop 0.
REQ-027 Reset asserted mid-window or with a pending result SHALL discard all data.
REQ-028 After reset release, the block SHALL start counting only after en=1 is sampled.

Structure
REQ-029 A shared package det_pkg SHALL hold the state encoding (IDLE=0, COUNT=1) and the default CNT_W/WIN_W constants.
REQ-030 The window timer (load, down-count, last-cycle flag) SHALL be one sub-module, det_win_timer; the rest SHALL be flat.

Verification
REQ-031 Basic window: win_len=5, en=1 held, det_in high in window cycles 1 and 4, cnt_ready=1 -> cnt_out=2, cnt_ovf=0, cnt_valid high 1 cycle after window cycle 5.
REQ-032 Back-to-back windows: win_len=3, det_in high every cycle, cnt_ready=1 -> a result of 3 every 3 cycles, no gap, drop never high.
REQ-033 Saturation and zero length:
- CNT_W=2, win_len=6, det_in high in all 6 window cycles -> cnt_out=3, cnt_ovf=1.
- win_len=0 -> 1-cycle windows.
REQ-034 Backpressure: win_len=2, cnt_ready=0 -> first result is held, drop pulses 1 cycle at each later window end; cnt_ready=1 at a window-end edge -> the new result loads and cnt_valid stays 1.
REQ-035 Abort: win_len=10, en=0 in window cycle 4 -> no cnt_valid, no drop, FSM IDLE; re-enable starts a fresh full 10-cycle window.
REQ-036 Async reset: rst pulsed mid-window with cnt_valid=1 -> all outputs 0 immediately, without waiting for a clk edge.
